mem_req_master: RTL and testbench
=================================

// Module: mem_req_master
// PURPOSE
//  Initiator side of the simple memory interface (addr, wr_en, rd_en, wdata, rdata).
//  - Accepts read and write commands on a valid/ready command port.
//  - Drives single-cycle enable strobes to a memory slave and captures rdata one cycle after rd_en.
//  - Returns read data in order through a small response FIFO on a valid/ready response port.
//  - Sits between the bus-side request logic and the memory core.
// PARAMETERS
//  ADDR_WIDTH  8   memory address width
//  DATA_WIDTH  32  memory data width
//  RSP_DEPTH   2   read-response FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1           clock; all logic on rising edge
//  reset      in   1           asynchronous, active-low reset
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           command accepted when cmd_valid && cmd_ready
//  cmd_we     in   1           1 = write, 0 = read
//  cmd_addr   in   ADDR_WIDTH  command address
//  cmd_wdata  in   DATA_WIDTH  write data; ignored for reads
//  rsp_valid  out  1           read data available
//  rsp_ready  in   1           consumer takes data when rsp_valid && rsp_ready
//  rsp_rdata  out  DATA_WIDTH  read data, FIFO head
//  addr       out  ADDR_WIDTH  memory address, registered
//  wr_en      out  1           memory write strobe, registered
//  rd_en      out  1           memory read strobe, registered
//  wdata      out  DATA_WIDTH  memory write data, registered
//  rdata      in   DATA_WIDTH  memory read data, valid the cycle after rd_en
// BEHAVIOUR
//  Reset (reset = 0, asynchronous)
//   - State = IDLE.
//   - wr_en, rd_en, addr, wdata = 0.
//   - FIFO empty: rsp_valid = 0, rsp_rdata = 0.
//   - cmd_ready = 0 while reset is asserted.
//   - Reset mid-operation aborts any in-flight access; its read data is discarded and never returned.
//  FSM states: IDLE, WRITE, READ, CAPTURE
//   - IDLE: cmd_ready = (fifo_count < RSP_DEPTH), combinational from state and count only.
//     On accept, cmd_addr/cmd_wdata are registered into addr/wdata; go to WRITE if cmd_we, else READ.
//   - WRITE: wr_en = 1 for exactly this cycle; addr/wdata stable. Next state IDLE.
//   - READ: rd_en = 1 for exactly this cycle; addr stable. Next state CAPTURE.
//   - CAPTURE: rd_en = 0. rdata is pushed into the FIFO at the end of this cycle. Next state IDLE.
//  Output rules
//   - cmd_ready = 0 in WRITE, READ and CAPTURE.
//   - Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
//   - Every strobe is preceded by a cycle with that strobe low, so each access is a rising edge.
//   - wr_en and rd_en are never both 1.
//   - addr/wdata change only on command accept and hold their last value in IDLE.
//   - wdata is updated on reads too (from cmd_wdata); don't-care to the memory.
//  Response FIFO
//   - rsp_valid = (count != 0); rsp_rdata = head entry.
//   - Pop on rsp_valid && rsp_ready.
//   - Accepting a read requires count < RSP_DEPTH, so the CAPTURE push never overflows.
//     Writes also wait when the FIFO is full.
//   - Push and pop in the same cycle: count unchanged, order preserved.
//   - Read and write pointers wrap modulo RSP_DEPTH; count is $clog2(RSP_DEPTH)+1 bits.
//   - rdata is captured verbatim, including X; no checking inside this block.
//  Latency
//   - Read: accept edge N -> rd_en high in cycle N+1 -> capture at edge N+2 -> rsp_valid high from N+2.
//   - Write: accept edge N -> wr_en high in cycle N+1.
// TESTING
//  1 Write: cmd we=1, addr=0x12, wdata=0xDEADBEEF
//    -> next cycle wr_en=1, addr=0x12, wdata=0xDEADBEEF, rd_en=0 for 1 cycle; cmd_ready low 1 cycle.
//  2 Read: cmd we=0, addr=0x34; memory returns 0xCAFE0001 one cycle after rd_en
//    -> rsp_valid=1 with rsp_rdata=0xCAFE0001 two edges after accept.
//  3 Fill: rsp_ready=0, RSP_DEPTH=2, reads to 0x01, 0x02, 0x03
//    -> 2 accepted, cmd_ready stays 0 for the third; pulse rsp_ready -> third accepted;
//       data returned in order 0x01, 0x02, 0x03.
//  4 Stream: rsp_ready=1 held, 8 back-to-back reads
//    -> count never exceeds 1, all 8 responses in order, no loss on simultaneous push/pop.
//  5 Reset in READ: assert reset while rd_en=1
//    -> rd_en=0 immediately, rsp_valid=0, no response after release, first new command handled normally.
//  6 Random: 1000 mixed commands with random rsp_ready
//    -> wr_en&&rd_en never 1; addr/wdata never X on a strobe; responses match a reference memory model.

Source files
------------

// File: rtl/mem_req_master.sv
// Memory-interface initiator: turns valid/ready commands into single-cycle
// wr_en/rd_en strobes and returns captured read data in order via a small FIFO.
module mem_req_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RSP_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

  state_t state;
  state_t next_state;

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  cmd_accept;
  logic                  fifo_push;
  logic                  fifo_pop;

  // Commands are only taken in IDLE and only if a read's response is
  // guaranteed a FIFO slot; writes wait on a full FIFO as well.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = reset && (fifo_count < DEPTH_CNT);
        if (cmd_valid && cmd_ready) begin
          next_state = cmd_we ? WRITE : READ;
        end
      end
      WRITE:   next_state = IDLE;
      READ:    next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign cmd_accept = cmd_valid && cmd_ready;

  // Strobes are registered from the next state, so each is high for exactly
  // the WRITE or READ cycle and reset drops them immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      state <= next_state;
      wr_en <= (next_state == WRITE);
      rd_en <= (next_state == READ);
      if (cmd_accept) begin
        addr  <= cmd_addr;
        wdata <= cmd_wdata;
      end
    end
  end

  assign fifo_push = (state == CAPTURE);
  assign rsp_valid = (fifo_count != '0);
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr];

  // Response FIFO; pointers wrap naturally because the depth is a power of 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= rdata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: a simple memory slave plus a
// reference memory/response queue that predicts every returned read word.
module tb_mem_req_master;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  mem_req_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .addr      (addr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wdata     (wdata),
    .rdata     (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] seed_word(input int a);
    logic [DW-1:0] v;
    v = DW'(a + 1) * 32'h9E37_79B9;
    return v ^ 32'h5A5A_0000;
  endfunction

  // Memory slave: loads seed contents until mem_loaded, then serves accesses
  // with rdata valid the cycle after rd_en.
  logic [DW-1:0] slave_mem [256];
  logic          mem_loaded;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) slave_mem[i] <= seed_word(i);
    end else begin
      if (wr_en) slave_mem[addr] <= wdata;
      if (rd_en) rdata <= slave_mem[addr];
    end
  end

  // Reference model: memory image updated at command acceptance, and the
  // queue of read words the DUT owes us, in command order.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int            vectors;
  int            miscompares;
  int            cycle_no;
  bit            last_acc;

  // Advance one clock: record the handshakes seen just before the edge.
  task automatic tick();
    bit            acc;
    bit            pop;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic [DW-1:0] p_data;
    #1;
    acc    = cmd_valid && cmd_ready;
    a_we   = cmd_we;
    a_addr = cmd_addr;
    a_data = cmd_wdata;
    pop    = rsp_valid && rsp_ready;
    p_data = rsp_rdata;
    @(posedge clk);
    cycle_no++;
    last_acc = acc;
    if (acc) begin
      if (a_we) ref_mem[a_addr] = a_data;
      else exp_q.push_back(ref_mem[a_addr]);
    end
    if (pop) got_q.push_back(p_data);
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int max_wait, output bit ok);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    ok        = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      tick();
      ok = last_acc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_responses(input int n, input int max_wait);
    for (int i = 0; i < max_wait && got_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 8'hAA;
    cmd_wdata = 32'h1234_5678;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en: got %b want 0", wr_en); end
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_en: got %b want 0", rd_en); end
    vectors++; if (addr !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_addr: got %h want 00", addr); end
    vectors++; if (wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h want 0", wdata); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    cmd_valid  = 1'b0;
    rsp_ready  = 1'b0;
    mem_loaded = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_write();
    bit ok;
    issue(1'b1, 8'h12, 32'hDEAD_BEEF, 4, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL write_accept: got %b want 1", ok); end
    vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL write_wr_en: got %b want 1", wr_en); end
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL write_rd_en: got %b want 0", rd_en); end
    vectors++; if (addr !== 8'h12) begin miscompares++; $display("[TB] FAIL write_addr: got %h want 12", addr); end
    vectors++; if (wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL write_wdata: got %h want deadbeef", wdata); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL write_busy_ready: got %b want 0", cmd_ready); end
    tick();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL write_strobe_end: got %b want 0", wr_en); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL write_ready_back: got %b want 1", cmd_ready); end
    vectors++; if (addr !== 8'h12 || wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL write_hold: got %h/%h want 12/deadbeef", addr, wdata); end
  endtask

  task automatic test_read();
    bit            ok;
    logic [DW-1:0] g;
    logic [DW-1:0] e;
    rsp_ready = 1'b0;
    issue(1'b1, 8'h34, 32'hCAFE_0001, 4, ok);
    issue(1'b0, 8'h34, $urandom, 4, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL read_accept: got %b want 1", ok); end
    vectors++; if (rd_en !== 1'b1 || wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL read_strobe: got rd=%b wr=%b want rd=1 wr=0", rd_en, wr_en); end
    vectors++; if (addr !== 8'h34) begin miscompares++; $display("[TB] FAIL read_addr: got %h want 34", addr); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL read_early_valid: got %b want 0", rsp_valid); end
    tick();
    vectors++; if (rd_en !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL read_capture: got rd=%b valid=%b ready=%b want 0/0/0", rd_en, rsp_valid, cmd_ready); end
    tick();
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL read_rsp_valid: got %b want 1", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'hCAFE_0001) begin miscompares++; $display("[TB] FAIL read_rsp_rdata: got %h want cafe0001", rsp_rdata); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL read_ready_one_entry: got %b want 1", cmd_ready); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL read_pop: got %b want 0", rsp_valid); end
    vectors++; if (got_q.size() !== 1 || exp_q.size() !== 1) begin miscompares++; $display("[TB] FAIL read_count: got %0d/%0d want 1/1", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL read_data: got %h want %h", g, e); end
    end
  endtask

  task automatic test_fill();
    bit            ok;
    bit            early;
    logic [DW-1:0] g;
    logic [DW-1:0] e;
    rsp_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      issue(1'b0, AW'(k), $urandom, 6, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_accept_%0d: got %b want 1", k, ok); end
    end
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 8'h03;
    early     = 1'b0;
    repeat (6) begin
      tick();
      if (last_acc) early = 1'b1;
    end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_overaccept: got %b want 0", early); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_ready_full: got %b want 0", cmd_ready); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3 && !ok; i++) begin
      tick();
      ok = last_acc;
    end
    cmd_valid = 1'b0;
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_third_accept: got %b want 1", ok); end
    rsp_ready = 1'b1;
    wait_responses(3, 12);
    rsp_ready = 1'b0;
    vectors++; if (got_q.size() !== 3 || exp_q.size() !== 3) begin miscompares++; $display("[TB] FAIL fill_count: got %0d/%0d want 3/3", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL fill_order: got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit            ok;
    int            prev;
    logic [DW-1:0] g;
    logic [DW-1:0] e;
    rsp_ready = 1'b1;
    prev = cycle_no;
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, AW'(8'h40 + k), $urandom, 4, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_write_accept_%0d: got %b want 1", k, ok); end
      if (k > 0) begin
        vectors++; if (cycle_no - prev !== 2) begin miscompares++; $display("[TB] FAIL b2b_write_spacing: got %0d want 2", cycle_no - prev); end
      end
      prev = cycle_no;
    end
    for (int k = 0; k < 8; k++) begin
      issue(1'b0, (k < 4) ? AW'(8'h40 + k) : AW'($urandom), $urandom, 5, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_read_accept_%0d: got %b want 1", k, ok); end
      if (k > 0) begin
        vectors++; if (cycle_no - prev !== 3) begin miscompares++; $display("[TB] FAIL b2b_read_spacing: got %0d want 3", cycle_no - prev); end
      end
      prev = cycle_no;
    end
    wait_responses(8, 10);
    vectors++; if (got_q.size() !== 8 || exp_q.size() !== 8) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d/%0d want 8/8", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL b2b_data: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_in_read();
    bit            ok;
    logic [DW-1:0] g;
    logic [DW-1:0] e;
    logic [DW-1:0] d;
    rsp_ready = 1'b0;
    issue(1'b0, 8'h21, $urandom, 4, ok);
    issue(1'b0, 8'h22, $urandom, 6, ok);
    vectors++; if (rd_en !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre_rd_en: got %b want 1", rd_en); end
    reset = 1'b0;
    #1;
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rd_en: got %b want 0", rd_en); end
    vectors++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_fifo: got valid=%b data=%h want 0/0", rsp_valid, rsp_rdata); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) tick();
    vectors++; if (got_q.size() !== 0 || rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stale_rsp: got %0d responses valid=%b want 0/0", got_q.size(), rsp_valid); end
    d = $urandom;
    issue(1'b1, 8'h77, d, 4, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_new_write: got %b want 1", ok); end
    issue(1'b0, 8'h77, $urandom, 4, ok);
    wait_responses(1, 6);
    vectors++; if (got_q.size() !== 1 || exp_q.size() !== 1) begin miscompares++; $display("[TB] FAIL rst_new_count: got %0d/%0d want 1/1", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++; if (g !== e || g !== d) begin miscompares++; $display("[TB] FAIL rst_new_data: got %h want %h", g, d); end
    end
  endtask

  task automatic test_random();
    int            accepted;
    int            cyc;
    bit            pending;
    logic          prev_wr;
    logic          prev_rd;
    logic [DW-1:0] g;
    logic [DW-1:0] e;
    accepted = 0;
    cyc      = 0;
    pending  = 1'b0;
    prev_wr  = wr_en;
    prev_rd  = rd_en;
    while (accepted < 1000 && cyc < 20000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 4) != 0) begin
        pending   = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom_range(0, 31));
        cmd_wdata = $urandom;
      end
      tick();
      cyc++;
      if (last_acc) begin
        accepted++;
        pending   = 1'b0;
        cmd_valid = 1'b0;
      end
      vectors++; if (wr_en && rd_en) begin miscompares++; $display("[TB] FAIL rand_both_strobes: got wr=%b rd=%b want not both", wr_en, rd_en); end
      vectors++; if ((wr_en && prev_wr) || (rd_en && prev_rd)) begin miscompares++; $display("[TB] FAIL rand_strobe_len: got wr=%b rd=%b held two cycles want one", wr_en, rd_en); end
      if (wr_en || rd_en) begin
        vectors++; if ($isunknown({addr, wdata})) begin miscompares++; $display("[TB] FAIL rand_x_on_strobe: got addr=%h wdata=%h want known", addr, wdata); end
      end
      prev_wr = wr_en;
      prev_rd = rd_en;
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL rand_extra_rsp: got %h want none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin miscompares++; $display("[TB] FAIL rand_data: got %h want %h", g, e); end
        end
      end
    end
    cmd_valid = 1'b0;
    vectors++; if (accepted !== 1000) begin miscompares++; $display("[TB] FAIL rand_timeout: got %0d accepted want 1000", accepted); end
    rsp_ready = 1'b1;
    wait_responses(exp_q.size(), 10);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL rand_drain_data: got %h want %h", g, e); end
    end
    vectors++; if (exp_q.size() !== 0 || got_q.size() !== 0) begin miscompares++; $display("[TB] FAIL rand_leftover: got %0d owed/%0d extra want 0/0", exp_q.size(), got_q.size()); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle_no    = 0;
    last_acc    = 1'b0;
    reset       = 1'b0;
    mem_loaded  = 1'b0;
    cmd_valid   = 1'b0;
    cmd_we      = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_fill();
    test_back_to_back();
    test_reset_in_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
